vector_exec_sequencer: RTL and testbench

Controller for the vector execute stage. It sequences a V-element vector operation through L parallel ALU lanes in ceil(V/L) chunks. It drives the chunk counter consumed by the fork and join vector blocks and latches the operation type and ALU control for the whole operation. It also generates the lane-valid mask, join write strobe, pipeline stall and completion pulse.

---
 rtl/vector_exec_sequencer.sv | 117 +++++++++++
 tb/tb_vector_exec_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vector_exec_sequencer.sv
// Vector execute stage sequencer: walks ceil(V/L) chunks, one per cycle after accept, then pulses done_o.
// Upstream is held via stall_o until the last chunk; new starts are only taken in IDLE or DONE.
module vector_exec_sequencer #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4,
  localparam int C  = (V + L - 1) / L,
  localparam int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_i,
  input  logic [1:0]    OpType_i,
  input  logic [1:0]    ALUControl_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          stall_o,
  output logic [CW-1:0] counter_o,
  output logic [L-1:0]  lane_en_o,
  output logic          join_we_o,
  output logic [1:0]    OpType_o,
  output logic [1:0]    ALUControl_o,
  output logic          done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Element width has no datapath here; it only has to be a sane value.
  localparam bit N_OK = (N > 0);

  state_t        state, state_nxt;
  logic [CW-1:0] counter, counter_nxt;
  logic [1:0]    op_q, op_nxt;
  logic [1:0]    alu_q, alu_nxt;
  logic          last_chunk;
  logic          accept;

  assign last_chunk = (counter == CW'(C - 1));
  assign accept     = N_OK && start_i && !flush_i &&
                      ((OpType_i == 2'b01) || (OpType_i == 2'b10));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      counter <= '0;
      op_q    <= 2'b00;
      alu_q   <= 2'b00;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      op_q    <= op_nxt;
      alu_q   <= alu_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    op_nxt      = op_q;
    alu_nxt     = alu_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = RUN;
          counter_nxt = '0;
          op_nxt      = OpType_i;
          alu_nxt     = ALUControl_i;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end else if (last_chunk) begin
          state_nxt   = DONE;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + CW'(1);
        end
      end
      DONE: begin
        // Back-to-back start skips IDLE so the only bubble is the DONE cycle.
        if (accept) begin
          state_nxt   = RUN;
          counter_nxt = '0;
          op_nxt      = OpType_i;
          alu_nxt     = ALUControl_i;
        end else begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  always_comb begin
    lane_en_o = '0;
    if (state == RUN) begin
      for (int j = 0; j < L; j++) begin
        if (int'(counter) * L + j < V) lane_en_o[j] = 1'b1;
      end
    end
  end

  assign busy_o       = (state == RUN);
  assign join_we_o    = (state == RUN);
  assign stall_o      = (state == RUN) && !last_chunk;
  assign done_o       = (state == DONE);
  assign counter_o    = counter;
  assign OpType_o     = op_q;
  assign ALUControl_o = alu_q;

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Scoreboard bench for vector_exec_sequencer: V=20 and V=18 instances share stimulus.
module tb_vector_exec_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start_i, flush_i;
  logic [1:0] OpType_i, ALUControl_i;

  logic       busy_a, stall_a, we_a, done_a;
  logic [2:0] cnt_a;
  logic [3:0] lane_a;
  logic [1:0] op_a, alu_a;

  logic       busy_b, stall_b, we_b, done_b;
  logic [2:0] cnt_b;
  logic [3:0] lane_b;
  logic [1:0] op_b, alu_b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic       done;
    logic       busy;
    logic       we;
    logic [2:0] cnt;
    logic [3:0] lane;
    logic       stall;
    logic [1:0] op;
    logic [1:0] alu;
  } exp_t;

  exp_t q20[$];
  exp_t q18[$];

  vector_exec_sequencer #(.N(32), .V(20), .L(4)) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .OpType_i(OpType_i),
    .ALUControl_i(ALUControl_i), .flush_i(flush_i), .busy_o(busy_a),
    .stall_o(stall_a), .counter_o(cnt_a), .lane_en_o(lane_a),
    .join_we_o(we_a), .OpType_o(op_a), .ALUControl_o(alu_a), .done_o(done_a)
  );

  vector_exec_sequencer #(.N(32), .V(18), .L(4)) dut18 (
    .CLK(CLK), .RST(RST), .start_i(start_i), .OpType_i(OpType_i),
    .ALUControl_i(ALUControl_i), .flush_i(flush_i), .busy_o(busy_b),
    .stall_o(stall_b), .counter_o(cnt_b), .lane_en_o(lane_b),
    .join_we_o(we_b), .OpType_o(op_b), .ALUControl_o(alu_b), .done_o(done_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input exp_t e);
    return {17'd0, 32'(e.cyc), e.done, e.busy, e.we, e.cnt, e.lane, e.stall, e.op, e.alu};
  endfunction

  function automatic exp_t mk(input int c, input logic d, input logic b, input logic w,
                              input logic [2:0] cn, input logic [3:0] ln, input logic s,
                              input logic [1:0] o, input logic [1:0] a);
    exp_t e;
    e.cyc = c; e.done = d; e.busy = b; e.we = w; e.cnt = cn;
    e.lane = ln; e.stall = s; e.op = o; e.alu = a;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask(input int v, input int k);
    logic [3:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (k * 4 + j < v) m[j] = 1'b1;
    return m;
  endfunction

  // Accept happens on the edge after 'base'; chunk k is seen at cyc base+1+k, done at base+6.
  task automatic push_op(input int base, input logic [1:0] op, input logic [1:0] alu,
                         input int nchunks, input bit with_done);
    for (int k = 0; k < nchunks; k++) begin
      q20.push_back(mk(base + 1 + k, 1'b0, 1'b1, 1'b1, 3'(k), lane_mask(20, k), k != 4, op, alu));
      q18.push_back(mk(base + 1 + k, 1'b0, 1'b1, 1'b1, 3'(k), lane_mask(18, k), k != 4, op, alu));
    end
    if (with_done) begin
      q20.push_back(mk(base + 6, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, op, alu));
      q18.push_back(mk(base + 6, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, op, alu));
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (busy_a || we_a || done_a) begin
      if (q20.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut20 unexpected output at cyc %0d: busy %b done %b cnt %0d", cyc, busy_a, done_a, cnt_a);
      end else begin
        e = q20.pop_front();
        check("dut20 event", pack(mk(cyc, done_a, busy_a, we_a, cnt_a, lane_a, stall_a, op_a, alu_a)), pack(e));
      end
    end
    if (busy_b || we_b || done_b) begin
      if (q18.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut18 unexpected output at cyc %0d: busy %b done %b cnt %0d", cyc, busy_b, done_b, cnt_b);
      end else begin
        e = q18.pop_front();
        check("dut18 event", pack(mk(cyc, done_b, busy_b, we_b, cnt_b, lane_b, stall_b, op_b, alu_b)), pack(e));
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, " dut20"}, 64'({done_a, busy_a, we_a, stall_a, cnt_a, lane_a, op_a, alu_a}), 64'd0);
    check({name, " dut18"}, 64'({done_b, busy_b, we_b, stall_b, cnt_b, lane_b, op_b, alu_b}), 64'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] alu);
    start_i = 1'b1; OpType_i = op; ALUControl_i = alu;
  endtask

  initial begin
    RST = 1'b0; start_i = 1'b0; flush_i = 1'b0; OpType_i = 2'b00; ALUControl_i = 2'b00;

    // Reset and idle, non-vector op types ignored.
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK); issue(2'b00, 2'b11);
    @(negedge CLK); issue(2'b11, 2'b10);
    @(negedge CLK); start_i = 1'b0;
    @(negedge CLK);
    check_all_zero("idle after bad optype");

    // Vector-vector single op.
    @(negedge CLK); issue(2'b01, 2'b00); push_op(cyc, 2'b01, 2'b00, 5, 1'b1);
    @(negedge CLK); start_i = 1'b0; OpType_i = 2'b00;
    repeat (8) @(negedge CLK);

    // Back-to-back: second start lands in the DONE cycle.
    issue(2'b01, 2'b10); push_op(cyc, 2'b01, 2'b10, 5, 1'b1);
    @(negedge CLK); start_i = 1'b0;
    repeat (5) @(negedge CLK);
    issue(2'b10, 2'b01); push_op(cyc, 2'b10, 2'b01, 5, 1'b1);
    @(negedge CLK); start_i = 1'b0; OpType_i = 2'b00; ALUControl_i = 2'b00;
    repeat (8) @(negedge CLK);

    // Input toggles during RUN, then flush at chunk 2.
    issue(2'b01, 2'b11); push_op(cyc, 2'b01, 2'b11, 3, 1'b0);
    @(negedge CLK); start_i = 1'b0;
    @(negedge CLK); issue(2'b10, 2'b00);
    @(negedge CLK); issue(2'b11, 2'b01); flush_i = 1'b1;
    @(negedge CLK); start_i = 1'b0; flush_i = 1'b0; OpType_i = 2'b00;
    check("flush idle dut20", 64'({busy_a, stall_a, done_a, we_a, cnt_a, lane_a, op_a, alu_a}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'b01, 2'b11}));
    check("flush idle dut18", 64'({busy_b, stall_b, done_b, we_b, cnt_b, lane_b, op_b, alu_b}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'b01, 2'b11}));
    repeat (3) @(negedge CLK);

    // Flush in IDLE blocks acceptance.
    issue(2'b10, 2'b10); flush_i = 1'b1;
    @(negedge CLK); start_i = 1'b0; flush_i = 1'b0;
    @(negedge CLK);
    check("flush blocks accept", 64'({busy_a, op_a, alu_a}), 64'({1'b0, 2'b01, 2'b11}));

    // Async reset at chunk 3.
    issue(2'b10, 2'b10); push_op(cyc, 2'b10, 2'b10, 4, 1'b0);
    @(negedge CLK); start_i = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); issue(2'b01, 2'b01); push_op(cyc, 2'b01, 2'b01, 5, 1'b1);
    @(negedge CLK); start_i = 1'b0;
    repeat (8) @(negedge CLK);

    check("dut20 scoreboard drained", 64'(q20.size()), 64'd0);
    check("dut18 scoreboard drained", 64'(q18.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
